// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Produces quotient and remainder N edges after a start is accepted.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N:0]     part_q, part_d;
  logic [N-1:0]   qreg_q, qreg_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // One extra bit keeps the borrow of the trial subtraction visible.
  logic [N+1:0]   pshift;
  logic [N+1:0]   trial;

  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    qreg_d  = qreg_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pshift  = {part_q, qreg_q[N-1]};
    trial   = pshift - {2'b00, dvs_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            dvs_d   = divisor;
            part_d  = '0;
            qreg_d  = dividend;
            cnt_d   = CW'(N);
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        part_d = trial[N+1] ? pshift[N:0] : trial[N:0];
        qreg_d = {qreg_q[N-2:0], ~trial[N+1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quot_d  = qreg_d;
          rem_d   = part_d[N-1:0];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      part_q  <= '0;
      qreg_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      qreg_q  <= qreg_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues operand pairs,
// a monitor checks every done pulse against plain-arithmetic division.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
  } op_t;

  op_t sb[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  logic         pd = 1'b0;
  logic         pbusy = 1'b0;
  logic [N-1:0] pq = '0;
  logic [N-1:0] pr = '0;
  logic         pz = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pd    = 1'b0;
      pbusy = 1'b0;
    end else begin
      if (done) begin
        chk("done_width", int'(pd), 0);
        chk("done_busy_excl", int'(busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          op_t o;
          int eq, er, ez;
          o  = sb.pop_front();
          ez = (o.b == 0) ? 1 : 0;
          eq = (o.b == 0) ? (1 << N) - 1 : o.a / o.b;
          er = (o.b == 0) ? o.a : o.a % o.b;
          chk($sformatf("quot %0d/%0d", o.a, o.b), int'(quotient), eq);
          chk($sformatf("rem %0d/%0d", o.a, o.b), int'(remainder), er);
          chk($sformatf("dbz %0d/%0d", o.a, o.b), int'(div_by_zero), ez);
          if (o.b != 0) begin
            chk("invariant", int'(quotient) * o.b + int'(remainder), o.a);
          end
        end
      end
      if (busy && pbusy) begin
        chk("hold_quot", int'(quotient), int'(pq));
        chk("hold_rem", int'(remainder), int'(pr));
        chk("hold_dbz", int'(div_by_zero), int'(pz));
      end
      pd    = done;
      pbusy = busy;
      pq    = quotient;
      pr    = remainder;
      pz    = div_by_zero;
    end
  end

  task automatic start_op(input int a, input int b, input bit push);
    op_t o;
    @(negedge clk);
    start    = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    o.a = a;
    o.b = b;
    if (push) sb.push_back(o);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
    end while (!done && lat < 4 * N);
  endtask

  task automatic op(input int a, input int b);
    int lat, nb;
    start_op(a, b, 1'b1);
    wait_done(lat, nb);
    chk($sformatf("latency %0d/%0d", a, b), lat, (b == 0) ? 1 : N + 1);
    chk($sformatf("busy_cycles %0d/%0d", a, b), nb, (b == 0) ? 0 : N);
  endtask

  initial begin
    int lat, nb;
    op_t o;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quot", int'(quotient), 0);
    chk("rst_rem", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    op(13, 3);
    op(15, 1);
    op(2, 9);
    op(7, 0);
    op(6, 2);

    // Start request during CALC must be ignored.
    start_op(12, 5, 1'b1);
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd1;
    @(posedge clk);
    #1;
    dividend = 4'd3;
    divisor  = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, nb);
    chk("ignore_lat", lat, 2);
    repeat (4) @(negedge clk);
    chk("ignore_queue", sb.size(), 0);

    // Asynchronous reset in the third CALC cycle.
    start_op(14, 4, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quot", int'(quotient), 0);
    chk("abort_rem", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    op(9, 2);

    // Start held high: re-accepted on the first idle edge after done.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd10;
    divisor  = 4'd3;
    o.a = 10;
    o.b = 3;
    sb.push_back(o);
    sb.push_back(o);
    wait_done(lat, nb);
    chk("b2b_lat1", lat, N + 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, nb);
    chk("b2b_lat2", lat, N + 1);

    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        op(a, b);
      end
    end

    for (int i = 0; i < 40; i++) begin
      op(int'($urandom_range((1 << N) - 1)), int'($urandom_range((1 << N) - 1)));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
